bcd2bin_seq: RTL and testbench

Iterative BCD-to-binary converter (reverse double-dabble). It is the inverse of the team's combinational binary-to-BCD path. It turns a DIGITS-digit packed BCD value (e.g. a timer/clock setpoint entered on switches) into a BIN_W-bit binary value for the TLC timers. Start/ready/done handshake; one correction-and-shift step per clock.

---
 rtl/bcd2bin_seq_pkg.sv | 18 +
 rtl/bcd2bin_seq_if.sv | 28 ++
 rtl/bcd2bin_seq_digit_corr.sv | 9 +
 rtl/bcd2bin_seq.sv | 103 ++++++++++
 tb/tb_bcd2bin_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the iterative BCD-to-binary converter.
package bcd2bin_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] BCD_MAX     = 4'd9;
   localparam logic [3:0] CORR_THRESH = 4'd8;
   localparam logic [3:0] CORR_VAL    = 4'd3;

   function automatic logic digit_invalid(input logic [3:0] d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/ready/done handshake bundle for bcd2bin_seq, plus a debug view of the FSM state.
interface bcd2bin_seq_if
   import bcd2bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   // start is taken only on an edge where ready=1; bcd_in is sampled on that
   // same edge. done pulses for one cycle; bin_out/err hold until the next accept.
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [BIN_W-1:0]      bin_out;
   state_e                state;

   modport master (
      output start, bcd_in,
      input  ready, busy, done, err, bin_out, state
   );

   modport slave (
      input  start, bcd_in,
      output ready, busy, done, err, bin_out, state
   );
endinterface

// File: rtl/bcd2bin_seq_digit_corr.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 when the digit is >= 8.
module bcd_digit_corr
   import bcd2bin_seq_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);
   assign d_o = (d_i >= CORR_THRESH) ? (d_i - CORR_VAL) : d_i;
endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter: one shift-and-correct step per clock over
// a {bcd, bin} working register, BIN_W steps per conversion.
module bcd2bin_seq
   import bcd2bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
)(
   input  logic           clk,
   input  logic           reset,
   bcd2bin_seq_if.slave   bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_e              state_q, state_d;
   logic [SR_W-1:0]     sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic                err_q, err_d;

   logic [SR_W-1:0]     shifted;
   logic [BCD_W-1:0]    corr_bcd;
   logic [SR_W-1:0]     sr_corr;
   logic                operand_bad;

   assign shifted = sr_q >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_digit_corr u_corr (
         .d_i (shifted[BIN_W + 4*g +: 4]),
         .d_o (corr_bcd[4*g +: 4])
      );
   end

   assign sr_corr = {corr_bcd, shifted[BIN_W-1:0]};

   always_comb begin
      operand_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_invalid(bus.bcd_in[4*i +: 4])) operand_bad = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (operand_bad) begin
                  // Malformed operand skips conversion entirely and reports at once.
                  err_d   = 1'b1;
                  bin_d   = '0;
                  state_d = DONE;
               end else begin
                  sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            sr_d  = sr_corr;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               bin_d   = sr_corr[BIN_W-1:0];
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready   = (state_q == IDLE);
   assign bus.busy    = (state_q == CONV);
   assign bus.done    = (state_q == DONE);
   assign bus.err     = err_q;
   assign bus.bin_out = bin_q;
   assign bus.state   = state_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: latency, results, error path, ignored start, reset abort, streaming.
module tb_bcd2bin_seq;
   import bcd2bin_seq_pkg::*;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   int   cyc;

   logic [9:0]  exp_q[$];
   logic [11:0] bcd_q[$];

   bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Advance one edge; outputs are looked at 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // driver: one accept starting in a ready cycle, then watch until done
   task automatic run_conv(input logic [11:0] bcd, output int lat, output int busy_n,
                           output bit seen);
      lat = 0; busy_n = 0; seen = 1'b0;
      bus.bcd_in = bcd;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_n++;
         lat++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.start = 1'b0;
      bus.bcd_in = '0;
      step(); step();
      reset = 1'b1;
      n_total++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.ready); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
      n_total++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else n_pass++;
      n_total++; if (bus.bin_out !== 10'd0) $display("FAIL reset_bin got=%0d exp=0", bus.bin_out); else n_pass++;
      n_total++; if (bus.state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE); else n_pass++;
   endtask

   task automatic test_convert(input string name, input logic [11:0] bcd, input logic [9:0] exp_bin);
      int lat, busy_n;
      bit seen;
      run_conv(bcd, lat, busy_n, seen);
      n_total++; if (!seen) $display("FAIL %s_done_timeout no done within 20 cycles", name); else n_pass++;
      n_total++; if (lat !== 10) $display("FAIL %s_latency got=%0d exp=10", name, lat); else n_pass++;
      n_total++; if (busy_n !== 10) $display("FAIL %s_busy_cycles got=%0d exp=10", name, busy_n); else n_pass++;
      n_total++; if (bus.bin_out !== exp_bin) $display("FAIL %s_bin got=%0d exp=%0d", name, bus.bin_out, exp_bin); else n_pass++;
      n_total++; if (bus.err !== 1'b0) $display("FAIL %s_err got=%b exp=0", name, bus.err); else n_pass++;
      n_total++; if (dut.sr_q[21:10] !== 12'h000) $display("FAIL %s_bcd_residue got=%h exp=000", name, dut.sr_q[21:10]); else n_pass++;
      step();
      n_total++; if (bus.ready !== 1'b1) $display("FAIL %s_ready_after got=%b exp=1", name, bus.ready); else n_pass++;
      n_total++; if (bus.bin_out !== exp_bin) $display("FAIL %s_bin_hold got=%0d exp=%0d", name, bus.bin_out, exp_bin); else n_pass++;
   endtask

   task automatic test_bad_digit();
      int lat, busy_n;
      bit seen;
      run_conv(12'h1A3, lat, busy_n, seen);
      n_total++; if (!seen) $display("FAIL bad_done_timeout no done within 20 cycles"); else n_pass++;
      n_total++; if (lat !== 0) $display("FAIL bad_latency got=%0d exp=0", lat); else n_pass++;
      n_total++; if (busy_n !== 0) $display("FAIL bad_busy_cycles got=%0d exp=0", busy_n); else n_pass++;
      n_total++; if (bus.err !== 1'b1) $display("FAIL bad_err got=%b exp=1", bus.err); else n_pass++;
      n_total++; if (bus.bin_out !== 10'd0) $display("FAIL bad_bin got=%0d exp=0", bus.bin_out); else n_pass++;
      step();
      n_total++; if (bus.ready !== 1'b1) $display("FAIL bad_ready_after got=%b exp=1", bus.ready); else n_pass++;
      n_total++; if (bus.err !== 1'b1) $display("FAIL bad_err_sticky got=%b exp=1", bus.err); else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int dones, late_dones, late_busy;
      logic [9:0] got_bin;
      dones = 0; late_dones = 0; late_busy = 0; got_bin = '0;
      bus.bcd_in = 12'h456;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
      step(); step();
      bus.bcd_in = 12'h123;
      bus.start  = 1'b1;
      step(); step(); step();
      bus.start  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (bus.done) begin
            dones++;
            got_bin = bus.bin_out;
         end
         step();
      end
      for (int i = 0; i < 15; i++) begin
         if (bus.done) late_dones++;
         if (bus.busy) late_busy++;
         step();
      end
      n_total++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d exp=1", dones); else n_pass++;
      n_total++; if (got_bin !== 10'd456) $display("FAIL ignore_bin got=%0d exp=456", got_bin); else n_pass++;
      n_total++; if (late_dones !== 0) $display("FAIL ignore_extra_done got=%0d exp=0", late_dones); else n_pass++;
      n_total++; if (late_busy !== 0) $display("FAIL ignore_extra_busy got=%0d exp=0", late_busy); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int dones;
      dones = 0;
      bus.bcd_in = 12'h789;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.done) dones++;
         step();
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      n_total++; if (bus.ready !== 1'b1) $display("FAIL abort_ready got=%b exp=1", bus.ready); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus.done); else n_pass++;
      n_total++; if (bus.bin_out !== 10'd0) $display("FAIL abort_bin got=%0d exp=0", bus.bin_out); else n_pass++;
      for (int i = 0; i < 15; i++) begin
         if (bus.done) dones++;
         step();
      end
      n_total++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else n_pass++;
   endtask

   // Streaming with start held high; scoreboard pops one expectation per done.
   task automatic test_back_to_back();
      int vals[16];
      int idx, checked, last_done;
      logic [9:0]  e_bin;
      logic [11:0] e_bcd;
      vals[0] = 0; vals[1] = 1; vals[2] = 9; vals[3] = 10;
      vals[4] = 99; vals[5] = 100; vals[6] = 500; vals[7] = 999;
      for (int i = 8; i < 16; i++) vals[i] = $urandom_range(0, 999);
      idx = 0; checked = 0; last_done = -1;
      bus.start = 1'b1;
      for (int c = 0; c < 16 * 12 + 40; c++) begin
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL stream_unexpected_done bin=%0d", bus.bin_out);
            end else begin
               e_bin = exp_q.pop_front();
               e_bcd = bcd_q.pop_front();
               n_total++; if (bus.bin_out !== e_bin) $display("FAIL stream_bin got=%0d exp=%0d", bus.bin_out, e_bin); else n_pass++;
               n_total++; if (to_bcd(int'(bus.bin_out)) !== e_bcd) $display("FAIL stream_roundtrip got=%h exp=%h", to_bcd(int'(bus.bin_out)), e_bcd); else n_pass++;
               if (last_done >= 0) begin
                  n_total++; if (cyc - last_done !== 12) $display("FAIL stream_period got=%0d exp=12", cyc - last_done); else n_pass++;
               end
               last_done = cyc;
               checked++;
            end
         end
         if (checked == 16) break;
         if (bus.ready) begin
            if (idx < 16) begin
               bus.bcd_in = to_bcd(vals[idx]);
               exp_q.push_back(10'(vals[idx]));
               bcd_q.push_back(to_bcd(vals[idx]));
               idx++;
            end else begin
               bus.start = 1'b0;
            end
         end
         step();
      end
      bus.start = 1'b0;
      n_total++; if (checked !== 16) $display("FAIL stream_count got=%0d exp=16", checked); else n_pass++;
      step(); step();
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      cyc = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.bcd_in = '0;
      test_reset();
      test_convert("zero", 12'h000, 10'd0);
      test_convert("v255", 12'h255, 10'h0FF);
      test_convert("v999", 12'h999, 10'h3E7);
      test_bad_digit();
      test_convert("after_err", 12'h042, 10'd42);
      test_start_while_busy();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
